oam_dma: RTL and testbench

Sprite OAM DMA engine between the 6502 core and the system memory bus. A CPU write of page number PP to the DMA register stalls the core through `rdy` and copies the 256 bytes at PP00–PPFF into sprite OAM. It drives the memory address mux while active and passes CPU bus traffic straight through when idle.

---
 rtl/oam_dma.sv | 127 ++++++++++++
 tb/tb_oam_dma.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- sprite OAM DMA engine.
//
// A CPU write of page number PP to DMA_REG_ADDR stalls the CPU (rdy low) and
// copies the 256 bytes at PP00..PPFF into sprite OAM, one READ + one WRITE
// cycle per byte. When idle the CPU address/write strobe pass straight to the
// memory bus.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   cpu_addr/dout/we  CPU bus request (dout carries the page on a trigger)
//   mem_din           memory read data, one-cycle latency after bus_addr
//   rdy               CPU ready; low while a transfer is in progress
//   busy              high in any state other than IDLE
//   bus_addr, bus_we  memory bus address mux / write enable
//   oam_addr/data/we  OAM write port
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_dout,
    input  logic                  cpu_we,
    input  logic [REG_WIDTH-1:0]  mem_din,
    output logic                  rdy,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_we,
    output logic [7:0]            oam_addr,
    output logic [REG_WIDTH-1:0]  oam_data,
    output logic                  oam_we
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] page, page_nxt;
    logic [7:0] idx, idx_nxt;
    logic       parity;
    logic       trigger;

    // {page, idx} is a plain concatenation: page FF ends at FFFF, no carry.
    logic [ADDR_WIDTH-1:0] dma_addr;
    assign dma_addr = ADDR_WIDTH'({page, idx});

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

    // Free-running cycle parity; decides whether an ALIGN cycle is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity <= 1'b0;
        else          parity <= ~parity;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            page  <= 8'd0;
            idx   <= 8'd0;
        end else begin
            state <= state_nxt;
            page  <= page_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        idx_nxt   = idx;
        rdy       = 1'b0;
        busy      = 1'b1;
        bus_addr  = cpu_addr;
        bus_we    = 1'b0;
        oam_addr  = idx;
        oam_data  = '0;
        oam_we    = 1'b0;

        case (state)
            IDLE: begin
                rdy    = 1'b1;
                busy   = 1'b0;
                bus_we = cpu_we;   // the trigger write itself also passes through
                if (trigger) begin
                    page_nxt  = cpu_dout[7:0];
                    idx_nxt   = 8'd0;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = parity ? ALIGN : READ;
            end
            ALIGN: begin
                state_nxt = READ;
            end
            READ: begin
                bus_addr  = dma_addr;
                state_nxt = WRITE;
            end
            WRITE: begin
                // mem_din now carries the byte addressed during the READ cycle
                bus_addr = dma_addr;
                oam_we   = 1'b1;
                oam_data = mem_din;
                if (idx == 8'hFF) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma -- randomized self-checking bench for oam_dma.
// Memory and OAM are modelled as plain arrays; expected OAM contents are the
// memory bytes at {page, i}, expected stall is 513 + cycle parity at HALT.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  mem_din;
    logic        rdy, busy, bus_we, oam_we;
    logic [15:0] bus_addr;
    logic [7:0]  oam_addr, oam_data;

    oam_dma dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .mem_din  (mem_din),
        .rdy      (rdy),
        .busy     (busy),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .oam_addr (oam_addr),
        .oam_data (oam_data),
        .oam_we   (oam_we)
    );

    always #5 clk = ~clk;

    logic [7:0] mem   [0:65535];
    logic [7:0] oam_m [0:255];
    int vectors = 0;
    int errors  = 0;
    int ecnt;

    // One-cycle read latency memory
    always @(posedge clk) mem_din <= mem[bus_addr];

    // Clock edges since reset: parity at HALT is (edges incl. trigger edge) % 2
    always @(posedge clk or negedge reset_n)
        if (!reset_n) ecnt <= 0;
        else          ecnt <= ecnt + 1;

    // Passive monitor: OAM model plus cumulative statistics
    int stall_n = 0, pulses = 0, order_err = 0, consec_err = 0;
    int we_err = 0, hold_err = 0, low_acc = 0;
    logic [7:0]  exp_idx = 8'd0;
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic [15:0] last_read = 16'h0;

    always @(negedge clk) begin
        if (!rdy) stall_n++;
        if (busy && bus_we) we_err++;
        if (busy && bus_addr < 16'h0100) low_acc++;
        if (oam_we) begin
            oam_m[oam_addr] = oam_data;
            pulses++;
            if (oam_addr != exp_idx) order_err++;
            exp_idx = exp_idx + 8'd1;
            if (prev_we) consec_err++;
            if (bus_addr != prev_addr) hold_err++;
            last_read = prev_addr;
        end
        if (!busy) exp_idx = 8'd0;
        prev_we   = oam_we;
        prev_addr = bus_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int oam_diff(input logic [7:0] pg, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++)
            if (oam_m[i] !== mem[{pg, i[7:0]}]) bad++;
        return bad;
    endfunction

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Issue the trigger write; returns the parity the engine sees in HALT.
    task automatic trigger(input logic [7:0] pg, input int want_par, input string nm, output int par);
        @(posedge clk); #1;
        if (want_par >= 0 && ((ecnt + 1) % 2) != want_par) begin
            @(posedge clk); #1;
        end
        par      = (ecnt + 1) % 2;
        cpu_addr = 16'h4014;
        cpu_dout = pg;
        cpu_we   = 1'b1;
        @(negedge clk);
        chk({nm, "_trig_pass"}, {15'd0, bus_we, bus_addr}, {15'd0, 1'b1, 16'h4014});
        @(posedge clk); #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        cpu_dout = 8'($urandom);
    endtask

    task automatic xfer(input logic [7:0] pg, input int want_par, input bit force_mid, input string nm);
        int p0, s0, o0, c0, w0, h0, l0, par;
        bit ok;
        p0 = pulses; s0 = stall_n; o0 = order_err; c0 = consec_err;
        w0 = we_err; h0 = hold_err; l0 = low_acc;
        trigger(pg, want_par, nm, par);
        if (force_mid) begin
            repeat (50) @(posedge clk);
            #1;
            cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h03;
            @(posedge clk); #1;
            cpu_we = 1'b0; cpu_addr = 16'h8000;
        end
        wait_idle(ok);
        chk({nm, "_done"},   32'(ok), 32'd1);
        chk({nm, "_stall"},  stall_n - s0, 513 + par);
        chk({nm, "_pulses"}, pulses - p0, 256);
        chk({nm, "_order"},  order_err - o0, 0);
        chk({nm, "_cadence"}, consec_err - c0, 0);
        chk({nm, "_hold"},   hold_err - h0, 0);
        chk({nm, "_bus_we"}, we_err - w0, 0);
        chk({nm, "_oam"},    oam_diff(pg, 0, 255), 0);
        chk({nm, "_idle"},   {30'd0, rdy, busy}, {30'd0, 2'b10});
        if (pg == 8'hFF) begin
            chk({nm, "_last_rd"}, {16'd0, last_read}, 32'h0000FFFF);
            chk({nm, "_no_wrap"}, low_acc - l0, 0);
        end
    endtask

    logic [7:0] old_oam [0:255];

    initial begin
        int p0, par;
        bit hit;
        logic [7:0] pr;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            oam_m[i] = 8'h00;
        end

        // Reset state
        reset_n = 1'b0; cpu_addr = 16'h1234; cpu_dout = 8'h00; cpu_we = 1'b0;
        @(negedge clk);
        chk("rst_rdy",      32'(rdy), 32'd1);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_oam_we",   32'(oam_we), 32'd0);
        chk("rst_oam_addr", 32'(oam_addr), 32'd0);
        chk("rst_oam_data", 32'(oam_data), 32'd0);
        chk("rst_bus_addr", {16'd0, bus_addr}, 32'h1234);
        chk("rst_bus_we",   32'(bus_we), 32'd0);
        #2 reset_n = 1'b1;

        // Idle non-trigger write passes through
        @(posedge clk); #1;
        cpu_addr = 16'h0010; cpu_dout = 8'h77; cpu_we = 1'b1;
        @(negedge clk);
        chk("idle_bus_we",   32'(bus_we), 32'd1);
        chk("idle_bus_addr", {16'd0, bus_addr}, 32'h0010);
        chk("idle_busy",     32'(busy), 32'd0);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h8000;
        @(negedge clk);
        chk("idle_after_busy", 32'(busy), 32'd0);

        xfer(8'h02, 0, 1'b0, "even");
        xfer(8'h02, 1, 1'b0, "odd");
        xfer(8'hFF, -1, 1'b0, "pageff");
        xfer(8'h02, -1, 1'b1, "forced");

        // Reset mid-transfer at READ of idx 100
        for (int i = 0; i < 256; i++) old_oam[i] = oam_m[i];
        pr = 8'h40;
        p0 = pulses;
        trigger(pr, -1, "midrst", par);
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            if (busy && !oam_we && bus_addr == {pr, 8'd100}) hit = 1'b1;
        end
        chk("midrst_found", 32'(hit), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_rdy",    32'(rdy), 32'd1);
        chk("midrst_busy",   32'(busy), 32'd0);
        chk("midrst_oam_we", 32'(oam_we), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_pulses", pulses - p0, 100);
        chk("midrst_head",   oam_diff(pr, 0, 99), 0);
        begin
            int bad = 0;
            for (int i = 100; i < 256; i++) if (oam_m[i] !== old_oam[i]) bad++;
            chk("midrst_tail", bad, 0);
        end
        xfer(pr, -1, 1'b0, "postrst");

        // Random pages and parities
        for (int t = 0; t < 3; t++)
            xfer(8'($urandom), int'($urandom_range(0, 1)), 1'b0, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
